// File: rtl/ttc_tx_pkg.sv
// Constants and types shared by the TTC downlink TX framer and the RX derandomizer:
// sync pattern, PN seed/feedback taps and the framer state encoding.
package ttc_tx_pkg;

  localparam logic [15:0] TTC_SYNC_WORD = 16'hEB90;
  localparam logic [7:0]  TTC_LFSR_SEED = 8'hFF;
  // Feedback into bit 7 is r0^r1^r2^r3^r4^r6
  localparam logic [7:0]  TTC_PN_TAPS   = 8'b0101_1111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_GUARD,
    ST_DATA
  } tx_state_t;

  function automatic logic [7:0] pn_step(input logic [7:0] state);
    return {^(state & TTC_PN_TAPS), state[7:1]};
  endfunction

endpackage

// File: rtl/pn_lfsr8.sv
// 8-bit PN generator for the TTC downlink: right shift, feedback into bit 7, output r0.
// Load has priority over Step so a reseed always wins.
module pn_lfsr8
  import ttc_tx_pkg::*;
#(
  parameter logic [7:0] RESET_SEED = TTC_LFSR_SEED
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Load,
  input  logic [7:0] Seed,
  input  logic       Step,
  output logic       Bit
);

  logic [7:0] lfsr_reg;
  logic [7:0] lfsr_next;

  always_comb begin
    lfsr_next = lfsr_reg;
    if (Load) begin
      lfsr_next = Seed;
    end else if (Step) begin
      lfsr_next = pn_step(lfsr_reg);
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      lfsr_reg <= RESET_SEED;
    end else begin
      lfsr_reg <= lfsr_next;
    end
  end

  assign Bit = lfsr_reg[0];

endmodule

// File: rtl/tx_randomizer.sv
// TTC downlink TX framer: sync word, guard zeros, then PN-randomized payload bytes,
// one bit per BitTickI, fed from a one-byte holding register.
module tx_randomizer
  import ttc_tx_pkg::*;
#(
  parameter logic [15:0] SYNC_WORD   = TTC_SYNC_WORD,
  parameter logic [7:0]  LFSR_SEED   = TTC_LFSR_SEED,
  parameter int          GUARD_BITS  = 1,
  parameter int          FRAME_BYTES = 64
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       StartI,
  input  logic       AbortI,
  input  logic [7:0] DataI,
  input  logic       DataValidI,
  output logic       DataReadyO,
  input  logic       BitTickI,
  output logic       DataO,
  output logic       EnO,
  output logic       SyncO,
  output logic       BusyO,
  output logic       DoneO,
  output logic       UnderrunO
);

  localparam logic [3:0] GUARD_LAST = (GUARD_BITS > 0) ? 4'(GUARD_BITS - 1) : 4'd0;
  localparam logic [7:0] LAST_BYTE  = 8'(FRAME_BYTES - 1);

  tx_state_t  state_reg, state_next;
  logic [3:0] bit_cnt_reg, bit_cnt_next;
  logic [7:0] byte_cnt_reg, byte_cnt_next;
  logic [7:0] shift_reg, shift_next;
  logic [7:0] hold_reg, hold_next;
  logic       hold_full_reg, hold_full_next;
  logic       data_reg, data_next;
  logic       en_reg, en_next;
  logic       sync_reg, sync_next;
  logic       done_reg, done_next;
  logic       underrun_reg, underrun_next;

  logic       lfsr_load;
  logic       lfsr_step;
  logic       lfsr_bit;
  logic       fetch;
  logic       take;

  pn_lfsr8 #(
    .RESET_SEED(LFSR_SEED)
  ) u_pn (
    .Clk (Clk),
    .Rst (Rst),
    .Load(lfsr_load),
    .Seed(LFSR_SEED),
    .Step(lfsr_step),
    .Bit (lfsr_bit)
  );

  assign take = DataValidI & ~hold_full_reg;

  always_comb begin
    state_next     = state_reg;
    bit_cnt_next   = bit_cnt_reg;
    byte_cnt_next  = byte_cnt_reg;
    shift_next     = shift_reg;
    hold_next      = hold_reg;
    hold_full_next = hold_full_reg;
    data_next      = data_reg;
    en_next        = 1'b0;
    sync_next      = 1'b0;
    done_next      = 1'b0;
    underrun_next  = 1'b0;
    lfsr_load      = 1'b0;
    lfsr_step      = 1'b0;
    fetch          = 1'b0;

    if (AbortI) begin
      state_next    = ST_IDLE;
      bit_cnt_next  = 4'd15;
      byte_cnt_next = 8'd0;
      shift_next    = 8'h00;
      lfsr_load     = 1'b1;
    end else begin
      unique case (state_reg)
        ST_IDLE: begin
          if (StartI) begin
            state_next    = ST_SYNC;
            bit_cnt_next  = 4'd15;
            byte_cnt_next = 8'd0;
            lfsr_load     = 1'b1;
          end
        end

        ST_SYNC: begin
          if (BitTickI) begin
            data_next = SYNC_WORD[bit_cnt_reg];
            en_next   = 1'b1;
            sync_next = 1'b1;
            if (bit_cnt_reg == 4'd0) begin
              if (GUARD_BITS == 0) begin
                state_next    = ST_DATA;
                bit_cnt_next  = 4'd7;
                byte_cnt_next = 8'd0;
                fetch         = 1'b1;
              end else begin
                state_next   = ST_GUARD;
                bit_cnt_next = GUARD_LAST;
              end
            end else begin
              bit_cnt_next = bit_cnt_reg - 4'd1;
            end
          end
        end

        ST_GUARD: begin
          if (BitTickI) begin
            data_next = 1'b0;
            en_next   = 1'b1;
            sync_next = 1'b1;
            if (bit_cnt_reg == 4'd0) begin
              state_next    = ST_DATA;
              bit_cnt_next  = 4'd7;
              byte_cnt_next = 8'd0;
              fetch         = 1'b1;
            end else begin
              bit_cnt_next = bit_cnt_reg - 4'd1;
            end
          end
        end

        ST_DATA: begin
          if (BitTickI) begin
            data_next  = shift_reg[7] ^ lfsr_bit;
            en_next    = 1'b1;
            lfsr_step  = 1'b1;
            shift_next = {shift_reg[6:0], 1'b0};
            if (bit_cnt_reg == 4'd0) begin
              if (byte_cnt_reg == LAST_BYTE) begin
                state_next   = ST_IDLE;
                bit_cnt_next = 4'd15;
                done_next    = 1'b1;
              end else begin
                byte_cnt_next = byte_cnt_reg + 8'd1;
                bit_cnt_next  = 4'd7;
                fetch         = 1'b1;
              end
            end else begin
              bit_cnt_next = bit_cnt_reg - 4'd1;
            end
          end
        end

        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end

    // An empty holding register still yields a byte slot: PN only, flagged as underrun
    if (fetch) begin
      if (hold_full_reg) begin
        shift_next     = hold_reg;
        hold_full_next = 1'b0;
      end else begin
        shift_next    = 8'h00;
        underrun_next = 1'b1;
      end
    end

    if (take) begin
      hold_next      = DataI;
      hold_full_next = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_reg     <= ST_IDLE;
      bit_cnt_reg   <= 4'd15;
      byte_cnt_reg  <= 8'd0;
      shift_reg     <= 8'h00;
      hold_reg      <= 8'h00;
      hold_full_reg <= 1'b0;
      data_reg      <= 1'b0;
      en_reg        <= 1'b0;
      sync_reg      <= 1'b0;
      done_reg      <= 1'b0;
      underrun_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      byte_cnt_reg  <= byte_cnt_next;
      shift_reg     <= shift_next;
      hold_reg      <= hold_next;
      hold_full_reg <= hold_full_next;
      data_reg      <= data_next;
      en_reg        <= en_next;
      sync_reg      <= sync_next;
      done_reg      <= done_next;
      underrun_reg  <= underrun_next;
    end
  end

  assign DataReadyO = ~hold_full_reg;
  assign DataO      = data_reg;
  assign EnO        = en_reg;
  assign SyncO      = sync_reg;
  assign BusyO      = (state_reg != ST_IDLE);
  assign DoneO      = done_reg;
  assign UnderrunO  = underrun_reg;

endmodule

// File: tb/tb_tx_randomizer.sv
// Randomized bench for tx_randomizer: captures every strobe and derandomizes it against
// a PN table computed arithmetically from the polynomial.
module tb_tx_randomizer;

  localparam int G    = 1;
  localparam int FB   = 4;
  localparam int FLEN = 16 + G + 8 * FB;
  localparam logic [15:0] SYNC_BITS = 16'b1110_1011_1001_0000;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic       StartI = 1'b0;
  logic       AbortI = 1'b0;
  logic [7:0] DataI = 8'h00;
  logic       DataValidI = 1'b0;
  logic       BitTickI = 1'b0;
  logic       DataReadyO, DataO, EnO, SyncO, BusyO, DoneO, UnderrunO;

  int tests_run = 0;
  int tests_failed = 0;

  logic       cap_bit[$];
  logic       cap_sync[$];
  logic       cap_done[$];
  int         underrun_cnt = 0;
  int         timing_viol = 0;
  logic       done_seen = 1'b0;
  logic       prev_busy = 1'b0;
  logic       prev_data = 1'b0;
  logic       prev_rst = 1'b0;
  logic [7:0] feed_q[$];
  logic       tick_en = 1'b0;
  int         tick_period = 1;
  int         tick_ph = 0;
  logic       pn_tab[8*FB];

  always #5 Clk = ~Clk;

  tx_randomizer #(
    .SYNC_WORD  (16'hEB90),
    .LFSR_SEED  (8'hFF),
    .GUARD_BITS (G),
    .FRAME_BYTES(FB)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .StartI    (StartI),
    .AbortI    (AbortI),
    .DataI     (DataI),
    .DataValidI(DataValidI),
    .DataReadyO(DataReadyO),
    .BitTickI  (BitTickI),
    .DataO     (DataO),
    .EnO       (EnO),
    .SyncO     (SyncO),
    .BusyO     (BusyO),
    .DoneO     (DoneO),
    .UnderrunO (UnderrunO)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Monitor: samples on the falling edge, records strobes and strobe-timing violations
  initial forever begin
    @(negedge Clk);
    if (Rst && prev_rst) begin
      if (EnO) begin
        cap_bit.push_back(DataO);
        cap_sync.push_back(SyncO);
        cap_done.push_back(DoneO);
      end
      if (DoneO) done_seen = 1'b1;
      if (UnderrunO) underrun_cnt++;
      if (EnO && (!BitTickI || !prev_busy)) timing_viol++;
      if (prev_busy && BitTickI && !AbortI && !EnO) timing_viol++;
      if (!EnO && DataO !== prev_data) timing_viol++;
    end
    prev_rst  = Rst;
    prev_busy = BusyO;
    prev_data = DataO;
  end

  initial forever begin
    @(negedge Clk);
    #1;
    if (tick_en) begin
      BitTickI = ((tick_ph % tick_period) == 0);
      tick_ph++;
    end else begin
      BitTickI = 1'b0;
      tick_ph  = 0;
    end
  end

  initial forever begin
    @(negedge Clk);
    #1;
    if (feed_q.size() > 0 && DataReadyO) begin
      DataI      = feed_q.pop_front();
      DataValidI = 1'b1;
    end else begin
      DataValidI = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge Clk);
    #1;
  endtask

  task automatic preload();
    int k = 0;
    while (DataReadyO && k < 20) begin
      step();
      k++;
    end
    check_eq("preload", 32'(DataReadyO), 32'(1'b0));
  endtask

  task automatic start_frame(output int base);
    base      = cap_bit.size();
    done_seen = 1'b0;
    StartI    = 1'b1;
    tick_en   = 1'b1;
    step();
    StartI    = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (!done_seen && k < 8 * FLEN + 40) begin
      step();
      k++;
    end
    check_eq({tag, "_done"}, 32'(done_seen), 32'(1'b1));
  endtask

  task automatic wait_bits(input string tag, input int base, input int nbits);
    int k = 0;
    while ((cap_bit.size() - base) < nbits && k < 8 * FLEN) begin
      step();
      k++;
    end
    check_eq({tag, "_reach"}, 32'((cap_bit.size() - base) >= nbits), 32'(1'b1));
  endtask

  task automatic check_frame(input string tag, input int base, input logic [7:0] exp_b [FB]);
    int         n;
    int         nsync;
    int         ndone;
    logic [15:0] sw;
    logic [7:0]  rx;
    n = cap_bit.size() - base;
    check_eq({tag, "_len"}, n, FLEN);
    if (n >= FLEN) begin
      sw = 16'h0000;
      nsync = 0;
      ndone = 0;
      for (int i = 0; i < 16; i++) sw = {sw[14:0], cap_bit[base + i]};
      check_eq({tag, "_sync"}, 32'(sw), 32'(SYNC_BITS));
      for (int i = 0; i < FLEN; i++) begin
        if (cap_sync[base + i] != (i < 16 + G)) nsync++;
        if (cap_done[base + i] != (i == FLEN - 1)) ndone++;
      end
      check_eq({tag, "_syncflag"}, nsync, 0);
      check_eq({tag, "_doneflag"}, ndone, 0);
      for (int i = 16; i < 16 + G; i++)
        check_eq($sformatf("%s_guard%0d", tag, i - 16), 32'(cap_bit[base + i]), 32'(1'b0));
      for (int b = 0; b < FB; b++) begin
        rx = 8'h00;
        for (int j = 0; j < 8; j++)
          rx = {rx[6:0], cap_bit[base + 16 + G + 8 * b + j] ^ pn_tab[8 * b + j]};
        check_eq($sformatf("%s_byte%0d", tag, b), 32'(rx), 32'(exp_b[b]));
      end
    end
  endtask

  initial begin
    logic [7:0] fa[FB];
    logic [7:0] fb[FB];
    logic [7:0] raw;
    int         base_a;
    int         base_b;
    int         u0;
    int         k;
    int         s;
    int         fbk;

    // PN reference: state starts at 0xFF, output is bit 0, feedback r0^r1^r2^r3^r4^r6 into bit 7
    s = 255;
    for (int i = 0; i < 8 * FB; i++) begin
      pn_tab[i] = 1'(s % 2);
      fbk = ((s >> 0) ^ (s >> 1) ^ (s >> 2) ^ (s >> 3) ^ (s >> 4) ^ (s >> 6)) % 2;
      s = (s / 2) + fbk * 128;
    end

    Rst = 1'b0;
    repeat (3) step();
    check_eq("reset_outputs",
             32'({DataO, EnO, SyncO, BusyO, DoneO, UnderrunO, DataReadyO}), 32'(7'b0000001));
    Rst = 1'b1;
    repeat (2) step();

    // Zero payload: first byte is pure PN from seed 0xFF, second byte continues the sequence
    fa = '{8'h00, 8'h00, 8'($urandom), 8'($urandom)};
    for (int i = 0; i < FB; i++) feed_q.push_back(fa[i]);
    preload();
    start_frame(base_a);
    wait_done("t1");
    check_frame("t1", base_a, fa);
    raw = 8'h00;
    for (int j = 0; j < 8; j++) raw = {raw[6:0], cap_bit[base_a + 16 + G + j]};
    check_eq("t1_pn_raw", 32'(raw), 32'(8'hFF));
    tick_en = 1'b0;
    repeat (3) step();

    // Slow bit strobe: one tick every 4 cycles
    tick_period = 4;
    for (int i = 0; i < FB; i++) fa[i] = 8'($urandom);
    for (int i = 0; i < FB; i++) feed_q.push_back(fa[i]);
    preload();
    start_frame(base_a);
    wait_done("t3");
    check_frame("t3", base_a, fa);
    check_eq("t3_timing", timing_viol, 0);
    tick_en = 1'b0;
    tick_period = 1;
    repeat (3) step();

    // Underrun on byte 1, late bytes become bytes 2 and 3
    for (int i = 0; i < FB; i++) fa[i] = 8'($urandom);
    feed_q.push_back(fa[0]);
    preload();
    u0 = underrun_cnt;
    start_frame(base_a);
    k = 0;
    while (underrun_cnt == u0 && k < 100) begin
      step();
      k++;
    end
    feed_q.push_back(fa[2]);
    feed_q.push_back(fa[3]);
    wait_done("t4");
    fa[1] = 8'h00;
    check_frame("t4", base_a, fa);
    check_eq("t4_underrun", underrun_cnt - u0, 1);
    tick_en = 1'b0;
    repeat (3) step();

    // Abort mid-payload; holding register survives and becomes the next frame's byte 0
    for (int i = 0; i < FB; i++) fa[i] = 8'($urandom);
    for (int i = 0; i < FB; i++) feed_q.push_back(fa[i]);
    preload();
    start_frame(base_a);
    wait_bits("t5", base_a, 20);
    check_eq("t5_hold_full", 32'(DataReadyO), 32'(1'b0));
    AbortI  = 1'b1;
    tick_en = 1'b0;
    feed_q.delete();
    step();
    AbortI = 1'b0;
    check_eq("t5_abort_state", 32'({BusyO, EnO, DoneO}), 32'(3'b000));
    check_eq("t5_no_done", 32'(done_seen), 32'(1'b0));
    step();
    fb[0] = fa[1];
    for (int i = 1; i < FB; i++) fb[i] = 8'($urandom);
    for (int i = 1; i < FB; i++) feed_q.push_back(fb[i]);
    preload();
    start_frame(base_b);
    wait_done("t5r");
    check_frame("t5r", base_b, fb);
    tick_en = 1'b0;
    repeat (3) step();

    // Back-to-back loopback frames with StartI in the DoneO cycle
    for (int it = 0; it < 3; it++) begin
      tick_period = $urandom_range(1, 2);
      for (int i = 0; i < FB; i++) fa[i] = 8'($urandom);
      for (int i = 0; i < FB; i++) fb[i] = 8'($urandom);
      for (int i = 0; i < FB; i++) feed_q.push_back(fa[i]);
      for (int i = 0; i < FB; i++) feed_q.push_back(fb[i]);
      preload();
      start_frame(base_a);
      wait_done($sformatf("t6a%0d", it));
      check_frame($sformatf("t6a%0d", it), base_a, fa);
      start_frame(base_b);
      wait_done($sformatf("t6b%0d", it));
      check_frame($sformatf("t6b%0d", it), base_b, fb);
      tick_en = 1'b0;
      repeat (2) step();
    end
    tick_period = 1;

    // Reset mid-frame, then a clean frame
    for (int i = 0; i < FB; i++) fa[i] = 8'($urandom);
    for (int i = 0; i < FB; i++) feed_q.push_back(fa[i]);
    preload();
    start_frame(base_a);
    wait_bits("t7", base_a, 25);
    Rst     = 1'b0;
    tick_en = 1'b0;
    feed_q.delete();
    #1;
    check_eq("t7_rst_outputs",
             32'({DataO, EnO, SyncO, BusyO, DoneO, UnderrunO, DataReadyO}), 32'(7'b0000001));
    step();
    Rst = 1'b1;
    repeat (2) step();
    for (int i = 0; i < FB; i++) fa[i] = 8'($urandom);
    for (int i = 0; i < FB; i++) feed_q.push_back(fa[i]);
    preload();
    start_frame(base_a);
    wait_done("t7r");
    check_frame("t7r", base_a, fa);
    tick_en = 1'b0;
    repeat (3) step();

    check_eq("timing_all", timing_viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/tx_randomizer.md
Name: tx_randomizer

Overview:
Transmit-side framer and randomizer for the TTC downlink bit stream. It accepts payload bytes over a valid/ready handshake and emits a serial frame. Each frame is the 16-bit sync word (MSB first, not randomized), then GUARD_BITS zero filler bits (not randomized), then FRAME_BYTES payload bytes (MSB first). The payload bits are XORed with an 8-bit PN LFSR that is reseeded at every frame start. It sits between the TX packet buffer and the modulator bit interface and produces exactly the stream the downlink derandomizer expects.

Parameters:
SYNC_WORD, 16'hEB90, sync pattern sent MSB first.
LFSR_SEED, 8'hFF, PN state loaded at each frame start.
GUARD_BITS, 1, unrandomized '0' bits between sync and payload (covers the receiver's arm cycle); range 0..7.
FRAME_BYTES, 64, payload bytes per frame; range 1..255.

Ports:
Clk  in  1  system clock
Rst  in  1  asynchronous, active-low reset
StartI  in  1  one-cycle pulse; begins a frame when idle
AbortI  in  1  synchronous abort; returns to IDLE
DataI  in  8  payload byte
DataValidI  in  1  DataI valid
DataReadyO  out  1  holding register empty; byte accepted when DataValidI & DataReadyO
BitTickI  in  1  bit-rate strobe from modulator (tie high for one bit/clock)
DataO  out  1  serial output bit
EnO  out  1  one-cycle strobe, DataO valid
SyncO  out  1  high with EnO while a sync or guard bit is on DataO
BusyO  out  1  high in any state except IDLE
DoneO  out  1  one-cycle pulse with the final payload bit's EnO
UnderrunO  out  1  one-cycle pulse when a payload byte was needed but holding register empty

Behaviour:
- Reset (Rst=0): state IDLE, LFSR=LFSR_SEED, holding register empty.
  - Outputs on reset: DataO=0, EnO=0, SyncO=0, BusyO=0, DoneO=0, UnderrunO=0, DataReadyO=1.
- Holding register: one byte.
  - DataReadyO = holding empty.
  - Loads are accepted in any state, including IDLE, so the first byte can be preloaded.
  - A transfer into the shift register and a new load in the same cycle are both honoured.
- FSM:
  - IDLE: on StartI go to SYNC. Bit counter=15. LFSR=LFSR_SEED.
  - SYNC: each BitTickI emits SYNC_WORD[cnt]. After bit 0, go to GUARD, or to DATA when GUARD_BITS=0.
  - GUARD: each BitTickI emits 0. After GUARD_BITS bits, go to DATA.
  - DATA: each BitTickI emits shift[7] ^ LFSR[0], then shifts the byte left and advances the LFSR.
    - Byte counter runs 0..FRAME_BYTES-1.
    - After the last bit of byte FRAME_BYTES-1, pulse DoneO and go to IDLE.
- LFSR: shift right; new[7] = r0^r1^r2^r3^r4^r6; new[6:0] = old[7:1]. It advances only on emitted payload bits.
- Byte fetch: on entry to DATA and after each byte's 8th bit, the shift register loads from the holding register.
  - If the holding register is empty, load 8'h00 and pulse UnderrunO.
  - The byte still counts, and the LFSR still runs.
- Output timing: DataO, EnO and SyncO are registered. A BitTickI at cycle t gives EnO=1 at t+1.
  - DataO holds its last value between strobes.
  - First sync bit: EnO at the cycle after the first BitTickI that follows the StartI cycle.
- StartI while busy: ignored.
- AbortI:
  - Has priority over StartI and BitTickI.
  - Next cycle: IDLE, EnO=0, LFSR reseeded, shift register cleared.
  - The holding register is kept.
  - DoneO is not pulsed.
- BitTickI in IDLE: no output.
- Reset mid-frame: immediate return to reset values; no partial-frame completion.
- Frame length in bits = 16 + GUARD_BITS + 8*FRAME_BYTES, exactly.
- Back-to-back frames: StartI in the DoneO cycle or later; any idle gap is allowed.

Decomposition:
- Shared package (ttc_tx_pkg):
  - SYNC_WORD, LFSR_SEED and the PN tap mask, shared with the RX derandomizer.
  - FSM state encoding: IDLE, SYNC, GUARD, DATA.
- One sub-module, pn_lfsr8.
  - Inputs: Clk, Rst, Load, Seed, Step.
  - Output: Bit = r0.
  - Same polynomial in RX/TX, unit-testable alone.

Test Plan:
1. Reset, preload 8'h00, StartI, BitTickI=1, FRAME_BYTES=1, GUARD_BITS=1 -> 25 EnO strobes.
   - Bits 1-16 = 1110101110010000 with SyncO=1.
   - Bit 17 = 0 with SyncO=1.
   - Bits 18-25 = 11111111 (PN of seed 8'hFF), SyncO=0.
   - DoneO with bit 25.
2. FRAME_BYTES=2, bytes 8'h00,8'h00 -> payload bit 9 = 0; payload equals the bit-accurate pn_lfsr8 model over 16 steps.
3. BitTickI every 4th cycle -> EnO exactly one cycle after each tick, DataO stable between strobes, frame length unchanged.
4. Holding register empty when byte 1 is needed -> UnderrunO one pulse, byte sent as PN only.
   - Then supply a byte: it is sent as byte 2, and DoneO is on time.
5. AbortI mid-DATA -> next cycle BusyO=0, EnO=0.
   - Following StartI restarts from sync with the LFSR reseeded; the first payload bits match test 1.
6. Loopback through the RX derandomizer with a random 64-byte payload -> recovered bytes identical, including back-to-back frames; Rst asserted mid-frame then released -> all outputs at reset values, next frame correct.
